decade_cascade_ctrl: RTL and testbench
======================================

// Module: decade_cascade_ctrl
// PURPOSE
//  Run/pause/clear sequencer for a chain of DIGITS cascaded decade (BCD 0-9) digits.
//  A prescaler paces the count: each count step increments the least significant digit (LSD).
//  A digit wrapping 9->0 carries into the next digit.
//  Sits between user controls (buttons/CPU strobes) and the display/timer logic; owns all digit state.
// PARAMETERS
//  DIGITS    4  number of cascaded BCD digits (1..8)
//  TICK_DIV  1  clock cycles per count step while running (>=1)
// PORTS
//  clock     in   1         system clock, rising edge
//  reset_n   in   1         asynchronous, active-low reset
//  start     in   1         run request (from IDLE or PAUSE)
//  stop      in   1         pause request (from RUN)
//  clear     in   1         zero all digits, return to IDLE
//  load      in   1         preset digits from load_val (IDLE/PAUSE only)
//  load_val  in   4*DIGITS  preset value, digit i = [4i+3:4i]
//  bcd       out  4*DIGITS  current count, digit i = [4i+3:4i]
//  running   out  1         1 while state==RUN
//  rollover  out  1         1-cycle pulse when all digits wrap 9..9 -> 0..0
// BEHAVIOUR
//  Single clock domain; reset_n asserts asynchronously and releases synchronously to the design.
//  Reset values: state=IDLE, bcd=0, running=0, rollover=0, prescaler=0.
//  FSM states: IDLE, RUN, PAUSE.
//   IDLE : start->RUN; load->bcd=load_val, stay IDLE.
//   RUN  : clear->IDLE (bcd=0); stop->PAUSE; load ignored.
//   PAUSE: clear->IDLE (bcd=0); start->RUN; load->bcd=load_val, stay PAUSE.
//  Command priority per edge: clear > stop > start > load.
//   start+stop together in PAUSE -> stays PAUSE.
//  Prescaler: counts 0..TICK_DIV-1 only in RUN; forced to 0 in IDLE/PAUSE.
//   Step fires on the edge where prescaler==TICK_DIV-1, state==RUN and no stop/clear that edge.
//  Latency: start sampled at edge k -> running=1 after k.
//   First bcd change at edge k+TICK_DIV (TICK_DIV=1: one count per clock).
//  Stop/clear sampled at edge m take effect at m: no increment at m.
//  Digit i increments when step & (digits 0..i-1 all ==9). A 9 wraps to 0; all other values +1.
//  rollover=1 for exactly the cycle after the edge where all digits were 9 and stepped; else 0.
//  Loaded digit >9 is forced to 0 (bcd never holds a non-BCD digit).
//  Reset mid-count: immediate return to reset values; the next start resumes from 0.
//  running is registered and equals (state==RUN).
// CONFIGURATION
//  `define LAP_CAPTURE_EN adds ports:
//   lap in 1; lap_bcd out 4*DIGITS; lap_valid out 1.
//   lap in RUN or PAUSE at edge n: lap_bcd <= bcd value before edge n, lap_valid <= 1.
//   clear or reset -> lap_bcd=0, lap_valid=0. lap in IDLE is ignored.
//  Without LAP_CAPTURE_EN: the three ports and their registers do not exist; all other behaviour is identical.
// STRUCTURE
//  Package decade_ctrl_pkg:
//   typedef enum {IDLE,RUN,PAUSE} ctrl_state_t;
//   DIGIT_W=4; BCD_MAX=4'd9.
//  Sub-module bcd_digit (one per digit, generate loop):
//   inputs clock, reset_n, clr, ld, ld_val[3:0], inc;
//   outputs q[3:0], at_max (q==9).
//   Carry chain: inc[i] = step & at_max[0..i-1].
//  Top level holds the FSM, prescaler and rollover/lap registers.
// TESTING
//  Reset: reset_n=0 mid-RUN at bcd=0x0123 -> bcd=0, running=0, rollover=0 immediately, without waiting for a clock edge.
//  DIGITS=2, TICK_DIV=1: start, 100 clocks -> bcd 00..99 then 00; rollover high exactly 1 cycle at the wrap.
//  TICK_DIV=3: start at edge k -> bcd=01 at k+3, 02 at k+6; stop at k+7 -> PAUSE, bcd holds 02.
//  load_val=0x09F9 in IDLE -> bcd=0x0909 (the 0xF digit forced to 0); load in RUN -> ignored.
//  Simultaneous clear+start in PAUSE -> IDLE, bcd=0; start+stop in PAUSE -> stays PAUSE.
//  LAP_CAPTURE_EN: lap at bcd=0x0042 in RUN -> lap_bcd=0x0042, lap_valid=1 while counting continues; clear -> both 0.

Source files
------------

// File: rtl/decade_ctrl_pkg.sv
// Shared types and constants for the decade cascade sequencer.
package decade_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } ctrl_state_t;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // A preset nibble above 9 is not a decimal digit, so it becomes 0.
  function automatic logic [DIGIT_W-1:0] bcd_sanitize(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? '0 : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the cascade: clear > load > increment, wraps 9 -> 0.
module bcd_digit
  import decade_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               at_max
);

  logic [DIGIT_W-1:0] r_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (ld) begin
      r_q <= bcd_sanitize(ld_val);
    end else if (inc) begin
      r_q <= (r_q == BCD_MAX) ? '0 : r_q + 4'd1;
    end
  end

  assign q      = r_q;
  assign at_max = (r_q == BCD_MAX);

endmodule

// File: rtl/decade_cascade_ctrl.sv
// Run/pause/clear sequencer for DIGITS cascaded BCD digits paced by a prescaler.
// Optional LAP_CAPTURE_EN adds lap, lap_bcd and lap_valid.
module decade_cascade_ctrl
  import decade_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*DIGITS-1:0]     load_val,
  output logic [4*DIGITS-1:0]     bcd,
  output logic                    running,
  output logic                    rollover
`ifdef LAP_CAPTURE_EN
  ,
  input  logic                    lap,
  output logic [4*DIGITS-1:0]     lap_bcd,
  output logic                    lap_valid
`endif
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  ctrl_state_t         r_state;
  ctrl_state_t         w_state_nxt;
  logic [PW-1:0]       r_presc;
  logic                r_running;
  logic                r_rollover;
  logic                w_step;
  logic                w_ld;
  logic [DIGITS-1:0]   w_inc;
  logic [DIGITS-1:0]   w_at_max;
  logic [4*DIGITS-1:0] w_bcd;

  // Command priority clear > stop > start > load: a higher command masks all lower ones.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (!stop && start) w_state_nxt = RUN;
        RUN:     if (stop)           w_state_nxt = PAUSE;
        PAUSE:   if (!stop && start) w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_step = (r_state == RUN) && (r_presc == P_LAST) && !stop && !clear;
  assign w_ld   = load && !clear && !stop && !start && (r_state != RUN);

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    if (g == 0) begin : g_lsd
      assign w_inc[g] = w_step;
    end else begin : g_upper
      assign w_inc[g] = w_step & (&w_at_max[g-1:0]);
    end

    bcd_digit u_digit (
      .clock  (clock),
      .reset_n(reset_n),
      .clr    (clear),
      .ld     (w_ld),
      .ld_val (load_val[4*g +: 4]),
      .inc    (w_inc[g]),
      .q      (w_bcd[4*g +: 4]),
      .at_max (w_at_max[g])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_presc    <= '0;
      r_running  <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_running  <= (w_state_nxt == RUN);
      r_rollover <= w_step & (&w_at_max);
      // Prescaler only advances across edges that stay in RUN, so each run starts from 0.
      if (r_state == RUN && w_state_nxt == RUN) begin
        r_presc <= (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
      end else begin
        r_presc <= '0;
      end
    end
  end

  assign bcd      = w_bcd;
  assign running  = r_running;
  assign rollover = r_rollover;

`ifdef LAP_CAPTURE_EN
  logic [4*DIGITS-1:0] r_lap_bcd;
  logic                r_lap_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lap_bcd   <= '0;
      r_lap_valid <= 1'b0;
    end else if (clear) begin
      r_lap_bcd   <= '0;
      r_lap_valid <= 1'b0;
    end else if (lap && r_state != IDLE) begin
      r_lap_bcd   <= w_bcd;
      r_lap_valid <= 1'b1;
    end
  end

  assign lap_bcd   = r_lap_bcd;
  assign lap_valid = r_lap_valid;
`endif

endmodule

// File: tb/tb_decade_cascade_ctrl.sv
// Self-checking bench for decade_cascade_ctrl: vector table plus scoreboarded sequences.
module tb_decade_cascade_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 4 digits, 3 clocks per step
  logic        a_start = 0, a_stop = 0, a_clear = 0, a_load = 0;
  logic [15:0] a_lv = '0;
  logic [15:0] a_bcd;
  logic        a_run, a_roll;
  // Instance B: 2 digits, one step per clock
  logic        b_start = 0, b_stop = 0, b_clear = 0, b_load = 0;
  logic [7:0]  b_lv = '0;
  logic [7:0]  b_bcd;
  logic        b_run, b_roll;
`ifdef LAP_CAPTURE_EN
  logic        a_lap = 0, b_lap = 0;
  logic [15:0] a_lap_bcd;
  logic [7:0]  b_lap_bcd;
  logic        a_lap_valid, b_lap_valid;
`endif

  decade_cascade_ctrl #(.DIGITS(4), .TICK_DIV(3)) u_a (
    .clock(clk), .reset_n(rst_n), .start(a_start), .stop(a_stop), .clear(a_clear),
    .load(a_load), .load_val(a_lv), .bcd(a_bcd), .running(a_run), .rollover(a_roll)
`ifdef LAP_CAPTURE_EN
    , .lap(a_lap), .lap_bcd(a_lap_bcd), .lap_valid(a_lap_valid)
`endif
  );

  decade_cascade_ctrl #(.DIGITS(2), .TICK_DIV(1)) u_b (
    .clock(clk), .reset_n(rst_n), .start(b_start), .stop(b_stop), .clear(b_clear),
    .load(b_load), .load_val(b_lv), .bcd(b_bcd), .running(b_run), .rollover(b_roll)
`ifdef LAP_CAPTURE_EN
    , .lap(b_lap), .lap_bcd(b_lap_bcd), .lap_valid(b_lap_valid)
`endif
  );

  typedef struct {
    logic [15:0] bcd;
    logic        run;
    logic        roll;
  } exp_t;

  typedef struct {
    logic        st, sp, cl, ld;
    logic [15:0] lv;
    logic [15:0] bcd;
    logic        run;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[32];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  function automatic exp_t mk(input logic [15:0] bcd, input logic run, input logic roll);
    exp_t e;
    e.bcd = bcd; e.run = run; e.roll = roll;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic a_cycle(input logic st, sp, cl, ld, input logic [15:0] lv,
                         input exp_t e, input string nm);
    exp_t x;
    @(negedge clk);
    a_start = st; a_stop = sp; a_clear = cl; a_load = ld; a_lv = lv;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    chk({nm, " bcd"}, a_bcd, x.bcd);
    chk({nm, " running"}, {15'd0, a_run}, {15'd0, x.run});
    chk({nm, " rollover"}, {15'd0, a_roll}, {15'd0, x.roll});
  endtask

  task automatic b_cycle(input logic st, sp, input exp_t e, input string nm);
    exp_t x;
    @(negedge clk);
    b_start = st; b_stop = sp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    chk({nm, " bcd"}, {8'd0, b_bcd}, x.bcd);
    chk({nm, " running"}, {15'd0, b_run}, {15'd0, x.run});
    chk({nm, " rollover"}, {15'd0, b_roll}, {15'd0, x.roll});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench still running, expected finish");
    $fatal(1);
  end

  initial begin
    // st sp cl ld  load_val   exp bcd  running
    tbl[0]  = '{0,0,0,1, 16'h09F9, 16'h0909, 0};
    tbl[1]  = '{0,0,0,0, 16'h0000, 16'h0909, 0};
    tbl[2]  = '{0,0,1,0, 16'h0000, 16'h0000, 0};
    tbl[3]  = '{1,0,0,0, 16'h0000, 16'h0000, 1};
    tbl[4]  = '{0,0,0,1, 16'h1234, 16'h0000, 1};
    tbl[5]  = '{0,0,0,0, 16'h0000, 16'h0000, 1};
    tbl[6]  = '{0,0,0,0, 16'h0000, 16'h0001, 1};
    tbl[7]  = '{0,0,0,0, 16'h0000, 16'h0001, 1};
    tbl[8]  = '{0,0,0,0, 16'h0000, 16'h0001, 1};
    tbl[9]  = '{0,0,0,0, 16'h0000, 16'h0002, 1};
    tbl[10] = '{0,1,0,0, 16'h0000, 16'h0002, 0};
    tbl[11] = '{0,0,0,0, 16'h0000, 16'h0002, 0};
    tbl[12] = '{1,1,0,0, 16'h0000, 16'h0002, 0};
    tbl[13] = '{0,0,0,1, 16'h0998, 16'h0998, 0};
    tbl[14] = '{1,0,0,0, 16'h0000, 16'h0998, 1};
    tbl[15] = '{0,0,0,0, 16'h0000, 16'h0998, 1};
    tbl[16] = '{0,0,0,0, 16'h0000, 16'h0998, 1};
    tbl[17] = '{0,0,0,0, 16'h0000, 16'h0999, 1};
    tbl[18] = '{0,0,0,0, 16'h0000, 16'h0999, 1};
    tbl[19] = '{0,0,0,0, 16'h0000, 16'h0999, 1};
    tbl[20] = '{0,0,0,0, 16'h0000, 16'h1000, 1};
    tbl[21] = '{0,1,0,0, 16'h0000, 16'h1000, 0};
    tbl[22] = '{1,0,1,0, 16'h0000, 16'h0000, 0};
    tbl[23] = '{1,0,0,0, 16'h0000, 16'h0000, 1};
    tbl[24] = '{0,0,0,0, 16'h0000, 16'h0000, 1};
    tbl[25] = '{0,0,0,0, 16'h0000, 16'h0000, 1};
    tbl[26] = '{0,0,0,0, 16'h0000, 16'h0001, 1};
    tbl[27] = '{0,0,0,0, 16'h0000, 16'h0001, 1};
    tbl[28] = '{0,0,0,0, 16'h0000, 16'h0001, 1};
    tbl[29] = '{0,1,0,0, 16'h0000, 16'h0001, 0};
    tbl[30] = '{0,0,0,1, 16'hA5F3, 16'h0503, 0};
    tbl[31] = '{0,0,1,0, 16'h0000, 16'h0000, 0};

    repeat (2) @(negedge clk);
    #1;
    chk("reset a bcd", a_bcd, 16'h0000);
    chk("reset a running", {15'd0, a_run}, 16'd0);
    chk("reset a rollover", {15'd0, a_roll}, 16'd0);
    chk("reset b bcd", {8'd0, b_bcd}, 16'h0000);
`ifdef LAP_CAPTURE_EN
    chk("reset lap_valid", {15'd0, a_lap_valid}, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      a_cycle(tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].ld, tbl[i].lv,
              mk(tbl[i].bcd, tbl[i].run, 1'b0), $sformatf("vec%0d", i));
    end

    // Two-digit full wrap, one count per clock
    b_cycle(1, 0, mk(16'h0000, 1, 0), "b start");
    for (int j = 1; j <= 101; j++) begin
      int m;
      m = j % 100;
      b_cycle(0, 0, mk({8'd0, 4'(m / 10), 4'(m % 10)}, 1, (j == 100)),
              $sformatf("b count%0d", j));
    end
    b_cycle(0, 1, mk(16'h0001, 0, 0), "b stop");
    b_cycle(0, 0, mk(16'h0001, 0, 0), "b hold");

    // Lap capture while counting
    a_cycle(0,0,0,1, 16'h0040, mk(16'h0040, 0, 0), "lap load");
    a_cycle(1,0,0,0, 16'h0000, mk(16'h0040, 1, 0), "lap start");
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0040, 1, 0), "lap p1");
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0040, 1, 0), "lap p2");
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0041, 1, 0), "lap s41");
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0041, 1, 0), "lap p4");
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0041, 1, 0), "lap p5");
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0042, 1, 0), "lap s42");
`ifdef LAP_CAPTURE_EN
    a_lap = 1'b1;
`endif
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0042, 1, 0), "lap take");
`ifdef LAP_CAPTURE_EN
    a_lap = 1'b0;
    chk("lap_bcd captured", a_lap_bcd, 16'h0042);
    chk("lap_valid set", {15'd0, a_lap_valid}, 16'd1);
`endif
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0042, 1, 0), "lap p8");
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0043, 1, 0), "lap s43");
`ifdef LAP_CAPTURE_EN
    chk("lap_bcd held", a_lap_bcd, 16'h0042);
    chk("lap_valid held", {15'd0, a_lap_valid}, 16'd1);
`endif
    a_cycle(0,0,1,0, 16'h0000, mk(16'h0000, 0, 0), "lap clear");
`ifdef LAP_CAPTURE_EN
    chk("lap_bcd cleared", a_lap_bcd, 16'h0000);
    chk("lap_valid cleared", {15'd0, a_lap_valid}, 16'd0);
`endif

    // Asynchronous reset mid-run, then restart from zero
    a_cycle(0,0,0,1, 16'h0123, mk(16'h0123, 0, 0), "rst load");
    a_cycle(1,0,0,0, 16'h0000, mk(16'h0123, 1, 0), "rst start");
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0123, 1, 0), "rst p1");
    @(negedge clk);
    a_start = 0; a_stop = 0; a_clear = 0; a_load = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst bcd", a_bcd, 16'h0000);
    chk("async rst running", {15'd0, a_run}, 16'd0);
    chk("async rst rollover", {15'd0, a_roll}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_cycle(1,0,0,0, 16'h0000, mk(16'h0000, 1, 0), "post rst start");
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0000, 1, 0), "post rst p1");
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0000, 1, 0), "post rst p2");
    a_cycle(0,0,0,0, 16'h0000, mk(16'h0001, 1, 0), "post rst step");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
